// File: rtl/pri_rr_arbiter.sv
// Priority arbiter with round-robin tie-breaking and a bounded hold time.
// The highest non-zero request level wins. Ties among equal levels are
// broken by scanning upward from rr_ptr. The grant stays with its owner
// until one of three things happens: done, the owner drops its request,
// or MAX_HOLD cycles pass.
module pri_rr_arbiter #(
  parameter int N = 4,
  parameter int P = 16,
  parameter int MAX_HOLD = 64,
  localparam int W = $clog2(P),
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  pri_in [0:N-1],
  input  logic          done,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic [W-1:0]  grant_pri,
  output logic          timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [N-1:0]  grant_n;
  logic          grant_valid_n;
  logic [IW-1:0] grant_idx_n;
  logic [W-1:0]  grant_pri_n;
  logic          timeout_n;

  logic [W-1:0]  max_pri;
  logic [IW-1:0] winner;
  logic          found;
  logic [IW:0]   pos;
  logic          rel;

  // Find the highest requested level this cycle
  always_comb begin
    max_pri = '0;
    for (int i = 0; i < N; i++) begin
      if (pri_in[i] > max_pri) max_pri = pri_in[i];
    end
  end

  // Pick the first requester at max_pri, scanning upward from rr_ptr with wrap
  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && pri_in[pos[IW-1:0]] == max_pri) begin
        found  = 1'b1;
        winner = pos[IW-1:0];
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    hold_cnt_n    = hold_cnt;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    grant_idx_n   = grant_idx;
    grant_pri_n   = grant_pri;
    timeout_n     = 1'b0;
    rel           = 1'b0;
    case (state)
      IDLE: begin
        if (max_pri != '0) begin
          grant_n       = ONE_HOT_0 << winner;
          grant_valid_n = 1'b1;
          grant_idx_n   = winner;
          grant_pri_n   = max_pri;
          hold_cnt_n    = '0;
          state_n       = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          rel = 1'b1;
        end else if (pri_in[grant_idx] == '0) begin
          rel = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          rel       = 1'b1;
          timeout_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
        if (rel) begin
          grant_n       = '0;
          grant_valid_n = 1'b0;
          grant_pri_n   = '0;
          rr_ptr_n      = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      grant_pri   <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      hold_cnt    <= hold_cnt_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_idx   <= grant_idx_n;
      grant_pri   <= grant_pri_n;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_pri_rr_arbiter.sv
// Scoreboard bench for pri_rr_arbiter.
// The stimulus side keeps a transaction-level model of the arbiter:
// who owns the resource, how long it has held it, and where the next
// tie-break scan starts. For every cycle it pushes the outputs expected
// after the coming edge. A separate monitor pops one entry per cycle and
// compares it against the registered outputs.
module tb_pri_rr_arbiter;

  localparam int N = 4;
  localparam int P = 16;
  localparam int W = 4;
  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [N-1:0] grant;
    logic         valid;
    logic [1:0]   idx;
    logic [W-1:0] pri;
    logic         timeout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pri_in [0:N-1];
  logic         done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [W-1:0] grant_pri;
  logic         timeout;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t mon_exp;

  bit m_busy = 0;
  int m_owner = 0;
  int m_pri = 0;
  int m_held = 0;
  int m_rr = 0;

  pri_rr_arbiter #(.N(N), .P(P), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .pri_in(pri_in),
    .done(done),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .grant_pri(grant_pri),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, predict the outputs after the next edge, and queue them
  task automatic applyStimulus(input int a, input int b, input int c, input int e,
                               input bit d, input bit r);
    int   lv [N];
    int   mx;
    bit   found;
    bit   to;
    exp_t ex;
    lv[0] = a; lv[1] = b; lv[2] = c; lv[3] = e;
    for (int i = 0; i < N; i++) pri_in[i] = W'(lv[i]);
    done = d;
    rst  = r;
    to   = 0;
    if (r) begin
      m_busy = 0; m_owner = 0; m_pri = 0; m_held = 0; m_rr = 0;
    end else if (!m_busy) begin
      mx = 0;
      for (int i = 0; i < N; i++) if (lv[i] > mx) mx = lv[i];
      if (mx != 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && lv[(m_rr + k) % N] == mx) begin
            found = 1;
            m_owner = (m_rr + k) % N;
          end
        end
        m_busy = 1;
        m_pri  = mx;
        m_held = 1;
      end
    end else begin
      if (d || lv[m_owner] == 0 || m_held == MAX_HOLD) begin
        to     = !d && lv[m_owner] != 0;
        m_busy = 0;
        m_pri  = 0;
        m_rr   = (m_owner + 1) % N;
      end else begin
        m_held++;
      end
    end
    ex.grant   = m_busy ? N'(1 << m_owner) : '0;
    ex.valid   = m_busy;
    ex.idx     = 2'(m_owner);
    ex.pri     = W'(m_pri);
    ex.timeout = to;
    sb.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  // Compare one expected entry against the DUT outputs
  task automatic checkOutput(input exp_t e);
    checks++;
    if (grant !== e.grant || grant_valid !== e.valid || grant_idx !== e.idx ||
        grant_pri !== e.pri || timeout !== e.timeout) begin
      failures++;
      $display("[TB] FAIL cycle_outputs t=%0t actual grant=%b valid=%b idx=%0d pri=%0d timeout=%b required grant=%b valid=%b idx=%0d pri=%0d timeout=%b",
               $time, grant, grant_valid, grant_idx, grant_pri, timeout,
               e.grant, e.valid, e.idx, e.pri, e.timeout);
    end
  endtask

  // Monitor: outputs are registered, so one scoreboard entry is retired per edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        checkOutput(mon_exp);
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int lv [N];
    bit d;
    bit r;

    // Reset, then idle with no requests
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Strict priority with a tie at 9, then done, then the other 9 gets the grant
    applyStimulus(3, 9, 5, 9, 0, 0);
    applyStimulus(3, 9, 5, 9, 0, 0);
    applyStimulus(3, 9, 5, 9, 1, 0);
    applyStimulus(3, 9, 5, 9, 0, 0);
    applyStimulus(3, 9, 5, 9, 0, 0);
    applyStimulus(3, 9, 5, 9, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Round-robin among equal levels with immediate done
    for (int i = 0; i < 12; i++) applyStimulus(7, 7, 7, 7, (i % 2) == 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Timeout on a single persistent requester
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Abandon by the owner
    applyStimulus(0, 5, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // done on the last allowed hold cycle
    applyStimulus(0, 5, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // done together with abandon
    applyStimulus(0, 0, 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Owner changes its level while busy; a higher level waits
    applyStimulus(0, 3, 0, 0, 0, 0);
    applyStimulus(0, 6, 15, 0, 0, 0);
    applyStimulus(0, 6, 15, 0, 1, 0);
    applyStimulus(0, 6, 15, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Reset while idx 3 holds the grant, then equal requests restart at idx 0
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 4, 0, 0);
    applyStimulus(0, 0, 0, 4, 0, 0);
    applyStimulus(6, 6, 6, 6, 0, 1);
    applyStimulus(6, 6, 6, 6, 0, 0);
    applyStimulus(6, 6, 6, 6, 1, 0);

    // Randomized traffic with frequent ties, occasional done and rare resets
    for (int i = 0; i < N; i++) lv[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) lv[i] = 4 * $urandom_range(0, 3);
      end
      d = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 79) == 0);
      applyStimulus(lv[0], lv[1], lv[2], lv[3], d, r);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Let the monitor retire the last entries, within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain actual pending=%0d required pending=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
